vend_multi: RTL and testbench

VEND_MULTI -- requirements
Module: vend_multi

---
 rtl/vend_multi_if.sv | 35 +++
 rtl/vend_multi.sv | 149 ++++++++++++++
 tb/tb_vend_multi.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_multi_if.sv
// Bus between a vending front panel (master) and the vend_multi controller (slave).
interface vend_multi_if #(
    parameter int unsigned N_ITEMS  = 4,
    parameter int unsigned CREDIT_W = 8
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic                Enable;
    logic                OneDollar;
    logic                FiftyCents;
    logic                TenCents;
    logic                FiveCents;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_item;
    logic                cancel;

    logic                Release;
    logic [SEL_W-1:0]    release_item;
    logic [CREDIT_W-1:0] credit;
    logic                change_pulse;
    logic                coin_reject;
    logic                sel_deny;

    modport master (
        output Enable, OneDollar, FiftyCents, TenCents, FiveCents,
        output sel_valid, sel_item, cancel,
        input  Release, release_item, credit, change_pulse, coin_reject, sel_deny
    );

    modport slave (
        input  Enable, OneDollar, FiftyCents, TenCents, FiveCents,
        input  sel_valid, sel_item, cancel,
        output Release, release_item, credit, change_pulse, coin_reject, sel_deny
    );
endinterface

// File: rtl/vend_multi.sv
// Multi-item vending controller: coin edge detection, credit, vend pulse and coin-by-coin change.
// Define VEND_AUTO_CHANGE_EN to refund residual credit automatically after every vend.
module vend_multi #(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned CREDIT_MAX = 255,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd1, 8'd6, 8'd3, 8'd5}
) (
    input logic         CLK,
    input logic         RST,
    vend_multi_if.slave bus
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam logic [CREDIT_W:0]   MAX_L      = (CREDIT_W+1)'(CREDIT_MAX);
    localparam logic [CREDIT_W:0]   V_DOLLAR   = (CREDIT_W+1)'(20);
    localparam logic [CREDIT_W:0]   V_FIFTY    = (CREDIT_W+1)'(10);
    localparam logic [CREDIT_W:0]   V_TEN      = (CREDIT_W+1)'(2);
    localparam logic [CREDIT_W:0]   V_FIVE     = (CREDIT_W+1)'(1);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    logic [1:0]          state, state_nxt;
    logic [CREDIT_W-1:0] credit_r, credit_nxt;
    logic [3:0]          coin_now, coin_prev, coin_rise;
    logic [CREDIT_W:0]   coin_val, coin_sum;
    logic                coin_multi, coin_single, coin_ok;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] price;
    logic                item_ok;

    logic                rel_r, rel_nxt;
    logic [SEL_W-1:0]    item_r, item_nxt;
    logic                chg_r, chg_nxt;
    logic                rej_r, rej_nxt;
    logic                deny_r, deny_nxt;

    assign coin_now    = {bus.OneDollar, bus.FiftyCents, bus.TenCents, bus.FiveCents};
    assign coin_rise   = coin_now & ~coin_prev;
    assign coin_multi  = (coin_rise & (coin_rise - 4'd1)) != 4'd0;
    assign coin_single = (coin_rise != 4'd0) && !coin_multi;
    assign coin_sum    = {1'b0, credit_r} + coin_val;
    assign coin_ok     = coin_single && (coin_sum <= MAX_L);
    assign credit_add  = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_r;

    always_comb begin
        coin_val = '0;
        case (coin_rise)
            4'b1000: coin_val = V_DOLLAR;
            4'b0100: coin_val = V_FIFTY;
            4'b0010: coin_val = V_TEN;
            4'b0001: coin_val = V_FIVE;
            default: coin_val = '0;
        endcase
    end

    // Out-of-range indices match no entry, leaving item_ok low so the selection is denied.
    always_comb begin
        price   = '0;
        item_ok = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (bus.sel_item == SEL_W'(i)) begin
                price   = PRICES[i*CREDIT_W +: CREDIT_W];
                item_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_r;
        rel_nxt    = 1'b0;
        item_nxt   = '0;
        rej_nxt    = coin_rise != 4'd0;
        deny_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                credit_nxt = '0;
                if (bus.Enable) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Price check uses pre-cycle credit; an accepted coin lands in the same update.
                rej_nxt    = coin_multi || (coin_single && !coin_ok);
                credit_nxt = credit_add;
                if (bus.cancel || !bus.Enable) begin
                    state_nxt = (credit_add != '0) ? S_CHANGE : S_IDLE;
                end else if (bus.sel_valid) begin
                    if (item_ok && (credit_r >= price)) begin
                        state_nxt  = S_VEND;
                        credit_nxt = credit_add - price;
                        rel_nxt    = 1'b1;
                        item_nxt   = bus.sel_item;
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end
            end
            S_VEND: begin
`ifdef VEND_AUTO_CHANGE_EN
                state_nxt = (credit_r != '0) ? S_CHANGE : S_WAIT;
`else
                state_nxt = S_WAIT;
`endif
            end
            S_CHANGE: begin
                credit_nxt = (credit_r != '0) ? credit_r - CREDIT_ONE : '0;
                if (credit_r <= CREDIT_ONE) state_nxt = bus.Enable ? S_WAIT : S_IDLE;
            end
            default: begin
                state_nxt  = S_IDLE;
                credit_nxt = '0;
            end
        endcase
        chg_nxt = (state_nxt == S_CHANGE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            credit_r  <= '0;
            coin_prev <= '0;
            rel_r     <= 1'b0;
            item_r    <= '0;
            chg_r     <= 1'b0;
            rej_r     <= 1'b0;
            deny_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            credit_r  <= credit_nxt;
            coin_prev <= coin_now;
            rel_r     <= rel_nxt;
            item_r    <= item_nxt;
            chg_r     <= chg_nxt;
            rej_r     <= rej_nxt;
            deny_r    <= deny_nxt;
        end
    end

    assign bus.Release      = rel_r;
    assign bus.release_item = item_r;
    assign bus.credit       = credit_r;
    assign bus.change_pulse = chg_r;
    assign bus.coin_reject  = rej_r;
    assign bus.sel_deny     = deny_r;
endmodule

// File: tb/tb_vend_multi.sv
// Scoreboard bench for vend_multi (CREDIT_MAX=40): directed scenarios plus randomized traffic vs a behavioural model.
module tb_vend_multi;
    localparam int CMAX = 40;

    typedef struct packed {
        logic       rel;
        logic [1:0] item;
        logic [7:0] cr;
        logic       chg;
        logic       rej;
        logic       deny;
    } out_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    vend_multi_if #(.N_ITEMS(4), .CREDIT_W(8)) bus ();

    vend_multi #(.CREDIT_MAX(40)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    bit   started  = 0;
    int   price_of[4] = '{5, 3, 6, 1};

    // Reference model: credit as a plain integer plus activity flags.
    int       m_cr     = 0;
    bit       m_on     = 0;
    bit       m_vend   = 0;
    bit       m_refund = 0;
    bit [3:0] m_prev   = 4'b0;

    task automatic model_step(input bit rst, input bit en, input bit [3:0] c, input bit sv,
                              input int unsigned it, input bit cn, output out_t e);
        bit [3:0] rise;
        int n, val, add, item;
        bit rel, rej, deny;
        rel = 0; rej = 0; deny = 0; item = 0; add = 0;
        if (rst) begin
            m_cr = 0; m_on = 0; m_vend = 0; m_refund = 0; m_prev = 4'b0;
            e = '0;
            return;
        end
        rise   = c & ~m_prev;
        m_prev = c;
        n      = $countones(rise);
        val    = rise[3] ? 20 : rise[2] ? 10 : rise[1] ? 2 : rise[0] ? 1 : 0;
        if (m_refund) begin
            rej = (n > 0);
            m_cr--;
            if (m_cr == 0) begin m_refund = 0; m_on = en; end
        end else if (m_vend) begin
            rej    = (n > 0);
            m_vend = 0;
`ifdef VEND_AUTO_CHANGE_EN
            m_refund = (m_cr > 0);
`endif
        end else if (!m_on) begin
            rej  = (n > 0);
            m_cr = 0;
            m_on = en;
        end else begin
            if (n == 1 && m_cr + val <= CMAX) add = val;
            rej = (n > 1) || (n == 1 && add == 0);
            if (cn || !en) begin
                m_cr += add;
                if (m_cr > 0) m_refund = 1;
                else m_on = 0;
            end else if (sv && m_cr >= price_of[it]) begin
                m_cr   = m_cr - price_of[it] + add;
                m_vend = 1;
                rel    = 1;
                item   = int'(it);
            end else begin
                deny = sv;
                m_cr += add;
            end
        end
        e.rel  = rel;
        e.item = 2'(item);
        e.cr   = 8'(m_cr);
        e.chg  = m_refund;
        e.rej  = rej;
        e.deny = deny;
    endtask

    task automatic drive(input bit rst, input bit en, input bit [3:0] c, input bit sv,
                         input int unsigned it, input bit cn);
        out_t e;
        @(negedge CLK);
        RST            = rst;
        bus.Enable     = en;
        bus.OneDollar  = c[3];
        bus.FiftyCents = c[2];
        bus.TenCents   = c[1];
        bus.FiveCents  = c[0];
        bus.sel_valid  = sv;
        bus.sel_item   = 2'(it);
        bus.cancel     = cn;
        model_step(rst, en, c, sv, it, cn, e);
        exp_q.push_back(e);
        started = 1;
    endtask

    task automatic idle(input int n, input bit en);
        repeat (n) drive(0, en, 4'b0, 0, 0, 0);
    endtask

    task automatic coin(input bit [3:0] c);
        drive(0, 1, c, 0, 0, 0);
        drive(0, 1, 4'b0, 0, 0, 0);
    endtask

    task automatic settle;
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: every clock after stimulus starts, pop one expected output set and compare.
    initial begin
        out_t a, e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.Release, bus.release_item, bus.credit, bus.change_pulse,
                     bus.coin_reject, bus.sel_deny};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got rel=%0d item=%0d credit=%0d chg=%0d rej=%0d deny=%0d, expected rel=%0d item=%0d credit=%0d chg=%0d rej=%0d deny=%0d",
                             $time, a.rel, a.item, a.cr, a.chg, a.rej, a.deny,
                             e.rel, e.item, e.cr, e.chg, e.rej, e.deny);
                end
            end else if (started) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard @%0t: got empty queue, expected an entry", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses, rejs;
        bus.Enable = 0; bus.OneDollar = 0; bus.FiftyCents = 0; bus.TenCents = 0;
        bus.FiveCents = 0; bus.sel_valid = 0; bus.sel_item = '0; bus.cancel = 0;

        drive(1, 0, 4'b0, 0, 0, 0);
        drive(1, 0, 4'b0, 0, 0, 0);
        settle;
        check("reset credit", int'(bus.credit), 0);
        check("reset release", int'(bus.Release), 0);

        // Dollar + dime, buy item 0
        drive(0, 1, 4'b0, 0, 0, 0);
        coin(4'b1000);
        coin(4'b0010);
        settle;
        check("credit after coins", int'(bus.credit), 22);
        drive(0, 1, 4'b0, 1, 0, 0);
        settle;
        check("vend release", int'(bus.Release), 1);
        check("vend item", int'(bus.release_item), 0);
        check("vend credit", int'(bus.credit), 17);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 4'b0, 0, 0, 0);
            settle;
            pulses += int'(bus.change_pulse);
        end
`ifdef VEND_AUTO_CHANGE_EN
        check("auto change pulses", pulses, 17);
        check("credit after auto change", int'(bus.credit), 0);
`else
        check("no auto change pulses", pulses, 0);
        check("residual credit kept", int'(bus.credit), 17);
`endif
        drive(0, 1, 4'b0, 0, 0, 1);
        idle(20, 1);

        // Held nickel counts once
        rejs = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 4'b0001, 0, 0, 0);
            settle;
            rejs += int'(bus.coin_reject);
        end
        drive(0, 1, 4'b0, 0, 0, 0);
        settle;
        check("held coin credit", int'(bus.credit), 1);
        check("held coin rejects", rejs, 0);

        // Two coins rising together
        drive(0, 1, 4'b0011, 0, 0, 0);
        settle;
        check("double coin reject", int'(bus.coin_reject), 1);
        check("double coin credit", int'(bus.credit), 1);
        drive(0, 1, 4'b0, 0, 0, 0);
        settle;
        check("reject is one cycle", int'(bus.coin_reject), 0);

        // Saturation at CREDIT_MAX
        coin(4'b1000); coin(4'b0100); coin(4'b0010); coin(4'b0010); coin(4'b0010); coin(4'b0001);
        settle;
        check("credit 38", int'(bus.credit), 38);
        drive(0, 1, 4'b0100, 0, 0, 0);
        settle;
        check("overflow reject", int'(bus.coin_reject), 1);
        check("overflow credit", int'(bus.credit), 38);
        drive(0, 1, 4'b0, 0, 0, 1);
        idle(45, 1);

        // Insufficient credit, then refund
        coin(4'b0010); coin(4'b0001);
        drive(0, 1, 4'b0, 1, 2, 0);
        settle;
        check("deny pulse", int'(bus.sel_deny), 1);
        check("deny no release", int'(bus.Release), 0);
        check("deny credit", int'(bus.credit), 3);
        drive(0, 1, 4'b0, 0, 0, 1);
        settle;
        pulses = int'(bus.change_pulse);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 4'b0, 0, 0, 0);
            settle;
            pulses += int'(bus.change_pulse);
        end
        check("refund pulses", pulses, 3);
        check("refund credit", int'(bus.credit), 0);
        coin(4'b0001);
        settle;
        check("back in wait accepts coin", int'(bus.credit), 1);
        drive(0, 1, 4'b0, 0, 0, 1);
        idle(5, 1);

        // Reset in the second change cycle
        coin(4'b0010); coin(4'b0010); coin(4'b0001);
        drive(0, 1, 4'b0, 0, 0, 1);
        drive(0, 1, 4'b0, 0, 0, 0);
        drive(1, 1, 4'b0, 0, 0, 0);
        settle;
        check("reset mid-change pulse", int'(bus.change_pulse), 0);
        check("reset mid-change credit", int'(bus.credit), 0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 4'b0, 0, 0, 0);
            settle;
            pulses += int'(bus.change_pulse);
        end
        check("no pulses after reset", pulses, 0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            bit [3:0] c;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) c = 4'b0;
            else if (r < 9) c = 4'(1 << $urandom_range(0, 3));
            else c = 4'($urandom);
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0, c,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 24) == 0);
        end

        settle;
        started = 0;
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
